// File: rtl/shift_add_multiplier_if.sv
`default_nettype none
// ============================================================================
// Module  : shift_add_multiplier_if
// Brief   : Request/result bundle for the sequential Booth multiplier.
// Revision: 1.0 - initial release
// ============================================================================
interface shift_add_multiplier_if #(
   parameter int SIZE = 8
);
   logic                  START;
   logic [SIZE-1:0]       A;
   logic [SIZE-1:0]       B;
   logic [2*SIZE-1:0]     S;
   logic                  END_MULT;

   modport master (output START, A, B, input  S, END_MULT);
   modport slave  (input  START, A, B, output S, END_MULT);
endinterface
`default_nettype wire

// File: rtl/shift_add_multiplier.sv
`default_nettype none
// ============================================================================
// Module  : shift_add_multiplier
// Brief   : Signed radix-2 Booth multiplier, one add/shift step per clock.
//           Optional MULT_SELFCHECK_EN adds simulation-only result assertions.
// Revision: 1.0 - initial release
// ============================================================================
module shift_add_multiplier #(
   parameter int SIZE = 8
) (
   input  wire logic                   CLK,
   input  wire logic                   RESET,
   shift_add_multiplier_if.slave       bus
);
   localparam int c_cnt_w = $clog2(SIZE + 1);

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_CALC = 2'd1,
      ST_DONE = 2'd2,
      ST_HOLD = 2'd3
   } state_t;

   state_t               r_state;
   state_t               w_state_nxt;
   logic [SIZE:0]        r_hi;
   logic [SIZE-1:0]      r_lo;
   logic                 r_q;
   logic [SIZE:0]        r_m;
   logic [c_cnt_w-1:0]   r_cnt;
   logic [2*SIZE-1:0]    r_s;
   logic                 r_end;
   logic [SIZE:0]        w_sum;

   always_ff @(posedge CLK) begin
      if (RESET) r_state <= ST_IDLE;
      else       r_state <= w_state_nxt;
   end

   always_comb begin
      w_state_nxt = r_state;
      case (r_state)
         ST_IDLE: if (bus.START) w_state_nxt = ST_CALC;
         ST_CALC: if (r_cnt == c_cnt_w'(1)) w_state_nxt = ST_DONE;
         ST_DONE: w_state_nxt = ST_HOLD;
         ST_HOLD: if (!bus.START) w_state_nxt = ST_IDLE;
         default: w_state_nxt = ST_IDLE;
      endcase
   end

   // Booth recoding of the current bit pair {LO[0], Q}
   always_comb begin
      w_sum = r_hi;
      case ({r_lo[0], r_q})
         2'b01:   w_sum = r_hi + r_m;
         2'b10:   w_sum = r_hi - r_m;
         default: w_sum = r_hi;
      endcase
   end

   always_ff @(posedge CLK) begin
      if (RESET) begin
         r_hi  <= '0;
         r_lo  <= '0;
         r_q   <= 1'b0;
         r_m   <= '0;
         r_cnt <= '0;
         r_s   <= '0;
         r_end <= 1'b0;
      end else begin
         r_end <= (r_state == ST_DONE);
         case (r_state)
            ST_IDLE: begin
               if (bus.START) begin
                  r_hi  <= '0;
                  r_lo  <= bus.B;
                  r_q   <= 1'b0;
                  r_m   <= {bus.A[SIZE-1], bus.A};
                  r_cnt <= c_cnt_w'(SIZE);
               end
            end
            ST_CALC: begin
               // arithmetic right shift of {sum, LO, Q}
               r_hi  <= {w_sum[SIZE], w_sum[SIZE:1]};
               r_lo  <= {w_sum[0], r_lo[SIZE-1:1]};
               r_q   <= r_lo[0];
               r_cnt <= r_cnt - c_cnt_w'(1);
            end
            ST_DONE: r_s <= {r_hi[SIZE-1:0], r_lo};
            default: ;
         endcase
      end
   end

   assign bus.S        = r_s;
   assign bus.END_MULT = r_end;

`ifdef MULT_SELFCHECK_EN
   logic [SIZE-1:0] r_a_copy;
   logic [SIZE-1:0] r_b_copy;
   logic            r_end_d;

   always_ff @(posedge CLK) begin
      if (RESET) begin
         r_a_copy <= '0;
         r_b_copy <= '0;
         r_end_d  <= 1'b0;
      end else begin
         if (r_state == ST_IDLE && bus.START) begin
            r_a_copy <= bus.A;
            r_b_copy <= bus.B;
         end
         r_end_d <= r_end;
         if (r_end) begin
            a_product: assert ($signed(r_s) == $signed(r_a_copy) * $signed(r_b_copy))
               else $error("product wrong: S=%h", r_s);
         end
         a_single_pulse: assert (!(r_end && r_end_d))
            else $error("END_MULT high two cycles in a row");
      end
   end
`else
`endif

endmodule
`default_nettype wire

// File: tb/tb_shift_add_multiplier.sv
`default_nettype none
// ============================================================================
// Module  : tb_shift_add_multiplier
// Brief   : Directed corners plus random operands against an arithmetic model.
// Revision: 1.0 - initial release
// ============================================================================
module tb_shift_add_multiplier;
   localparam int c_size = 8;

   logic clk = 1'b0;
   logic rst = 1'b1;
   int   n_checks = 0;
   int   n_errors = 0;
   bit   cov [256];

   shift_add_multiplier_if #(.SIZE(c_size)) mif ();

   shift_add_multiplier #(.SIZE(c_size)) dut (
      .CLK   (clk),
      .RESET (rst),
      .bus   (mif.slave)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      if (obs !== exp) begin
         n_errors++;
         $display("FAIL %s: got %h expected %h", tag, obs, exp);
      end
   endtask

   function automatic logic [15:0] ref_prod(input logic signed [7:0] a, input logic signed [7:0] b);
      int p;
      p = int'(a) * int'(b);
      return p[15:0];
   endfunction

   task automatic do_mult(input logic signed [7:0] a, input logic signed [7:0] b, input bit hold_start);
      int          cycles;
      logic [15:0] exp;
      exp = ref_prod(a, b);
      @(negedge clk);
      mif.A = a; mif.B = b; mif.START = 1'b1;
      @(posedge clk);
      #1;
      if (!hold_start) mif.START = 1'b0;
      mif.A = 8'($urandom); mif.B = 8'($urandom);
      cycles = 0;
      while (!mif.END_MULT && cycles < 40) begin
         @(posedge clk); #1; cycles++;
      end
      check("latency", cycles, c_size + 1);
      check("end_pulse", {31'd0, mif.END_MULT}, 32'd1);
      check("product", {16'd0, mif.S}, {16'd0, exp});
      @(posedge clk); #1;
      check("end_low", {31'd0, mif.END_MULT}, 32'd0);
      if (hold_start) begin
         for (int i = 0; i < 5; i++) begin
            @(posedge clk); #1;
            check("hold_no_retrigger", {31'd0, mif.END_MULT}, 32'd0);
         end
         check("hold_s_stable", {16'd0, mif.S}, {16'd0, exp});
         mif.START = 1'b0;
      end
      @(posedge clk); #1;
      check("product_late", {16'd0, mif.S}, {16'd0, exp});
   endtask

   initial begin
      int covered;
      int ops;
      logic signed [7:0] ra, rb;
      mif.START = 1'b0; mif.A = '0; mif.B = '0;
      repeat (3) @(posedge clk);
      #1;
      check("reset_s", {16'd0, mif.S}, 32'd0);
      check("reset_end", {31'd0, mif.END_MULT}, 32'd0);
      @(negedge clk); rst = 1'b0;

      do_mult(8'sd45,   8'sd96,   1'b0);
      do_mult(-8'sd45,  8'sd96,   1'b0);
      do_mult(8'sd45,   -8'sd96,  1'b0);
      do_mult(-8'sd45,  -8'sd96,  1'b0);
      do_mult(-8'sd128, -8'sd128, 1'b0);
      do_mult(-8'sd128, 8'sd127,  1'b0);
      do_mult(8'sd0,    -8'sd1,   1'b0);
      do_mult(8'sd13,   -8'sd7,   1'b1);

      // abort mid-operation: S from the previous operation is nonzero
      @(negedge clk);
      mif.A = 8'sd100; mif.B = 8'sd3; mif.START = 1'b1;
      @(posedge clk); #1; mif.START = 1'b0;
      repeat (3) @(posedge clk);
      @(negedge clk); rst = 1'b1;
      @(posedge clk); #1;
      check("abort_s", {16'd0, mif.S}, 32'd0);
      check("abort_end", {31'd0, mif.END_MULT}, 32'd0);
      @(negedge clk); rst = 1'b0;
      for (int i = 0; i < c_size + 4; i++) begin
         @(posedge clk); #1;
         check("abort_no_end", {31'd0, mif.END_MULT}, 32'd0);
      end
      do_mult(8'sd7, -8'sd3, 1'b0);

      covered = 0;
      ops = 0;
      while (covered * 100 <= 256 * 90 && ops < 3000) begin
         ra = 8'($urandom);
         rb = 8'($urandom);
         if (!cov[{ra[7:4], rb[7:4]}]) begin
            cov[{ra[7:4], rb[7:4]}] = 1'b1;
            covered++;
         end
         do_mult(ra, rb, 1'b0);
         ops++;
      end
      check("coverage_reached", {31'd0, (covered * 100 > 256 * 90)}, 32'd1);

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end
endmodule
`default_nettype wire
